// File: rtl/axi_mmio_arbiter.sv
// Two-master AXI4-Lite arbiter in front of the MMIO controller: one outstanding
// transaction at a time, round-robin between masters, DECERR for off-window addresses.
module axi_mmio_arbiter #(
    parameter logic [15:0] MMIO_BASE = 16'h4600
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic [31:0] S0_AXI_awaddr,
    input  logic [2:0]  S0_AXI_awprot,
    input  logic        S0_AXI_awvalid,
    output logic        S0_AXI_awready,
    input  logic [31:0] S0_AXI_wdata,
    input  logic [3:0]  S0_AXI_wstrb,
    input  logic        S0_AXI_wvalid,
    output logic        S0_AXI_wready,
    output logic [1:0]  S0_AXI_bresp,
    output logic        S0_AXI_bvalid,
    input  logic        S0_AXI_bready,
    input  logic [31:0] S0_AXI_araddr,
    input  logic [2:0]  S0_AXI_arprot,
    input  logic        S0_AXI_arvalid,
    output logic        S0_AXI_arready,
    output logic [31:0] S0_AXI_rdata,
    output logic [1:0]  S0_AXI_rresp,
    output logic        S0_AXI_rvalid,
    input  logic        S0_AXI_rready,
    input  logic [31:0] S1_AXI_awaddr,
    input  logic [2:0]  S1_AXI_awprot,
    input  logic        S1_AXI_awvalid,
    output logic        S1_AXI_awready,
    input  logic [31:0] S1_AXI_wdata,
    input  logic [3:0]  S1_AXI_wstrb,
    input  logic        S1_AXI_wvalid,
    output logic        S1_AXI_wready,
    output logic [1:0]  S1_AXI_bresp,
    output logic        S1_AXI_bvalid,
    input  logic        S1_AXI_bready,
    input  logic [31:0] S1_AXI_araddr,
    input  logic [2:0]  S1_AXI_arprot,
    input  logic        S1_AXI_arvalid,
    output logic        S1_AXI_arready,
    output logic [31:0] S1_AXI_rdata,
    output logic [1:0]  S1_AXI_rresp,
    output logic        S1_AXI_rvalid,
    input  logic        S1_AXI_rready,
    output logic [31:0] M_AXI_awaddr,
    output logic [2:0]  M_AXI_awprot,
    output logic        M_AXI_awvalid,
    input  logic        M_AXI_awready,
    output logic [31:0] M_AXI_wdata,
    output logic [3:0]  M_AXI_wstrb,
    output logic        M_AXI_wvalid,
    input  logic        M_AXI_wready,
    input  logic [1:0]  M_AXI_bresp,
    input  logic        M_AXI_bvalid,
    output logic        M_AXI_bready,
    output logic [31:0] M_AXI_araddr,
    output logic [2:0]  M_AXI_arprot,
    output logic        M_AXI_arvalid,
    input  logic        M_AXI_arready,
    input  logic [31:0] M_AXI_rdata,
    input  logic [1:0]  M_AXI_rresp,
    input  logic        M_AXI_rvalid,
    output logic        M_AXI_rready,
    output logic        busy,
    output logic        grant_id
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_RESP} state_t;

    state_t      r_state, cur_state, nxt_state;
    logic        r_grant, r_last, r_err;
    logic        req0, req1, arb_gnt, arb_wr;
    logic [15:0] arb_hi;

    // Channels of the granted master
    logic [31:0] g_awaddr, g_wdata, g_araddr, g_rdata;
    logic [2:0]  g_awprot, g_arprot;
    logic [3:0]  g_wstrb;
    logic [1:0]  g_bresp, g_rresp;
    logic        g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
    logic        g_awready, g_wready, g_bvalid, g_arready, g_rvalid;

    // Reset forces every output to its idle value even before the edge.
    assign cur_state = arst ? IDLE : r_state;

    assign req0    = S0_AXI_awvalid | S0_AXI_arvalid;
    assign req1    = S1_AXI_awvalid | S1_AXI_arvalid;
    assign arb_gnt = (req0 & req1) ? ~r_last : req1;
    assign arb_wr  = arb_gnt ? S1_AXI_awvalid : S0_AXI_awvalid;
    assign arb_hi  = arb_wr ? (arb_gnt ? S1_AXI_awaddr[31:16] : S0_AXI_awaddr[31:16])
                            : (arb_gnt ? S1_AXI_araddr[31:16] : S0_AXI_araddr[31:16]);

    assign g_awaddr  = r_grant ? S1_AXI_awaddr  : S0_AXI_awaddr;
    assign g_awprot  = r_grant ? S1_AXI_awprot  : S0_AXI_awprot;
    assign g_awvalid = r_grant ? S1_AXI_awvalid : S0_AXI_awvalid;
    assign g_wdata   = r_grant ? S1_AXI_wdata   : S0_AXI_wdata;
    assign g_wstrb   = r_grant ? S1_AXI_wstrb   : S0_AXI_wstrb;
    assign g_wvalid  = r_grant ? S1_AXI_wvalid  : S0_AXI_wvalid;
    assign g_bready  = r_grant ? S1_AXI_bready  : S0_AXI_bready;
    assign g_araddr  = r_grant ? S1_AXI_araddr  : S0_AXI_araddr;
    assign g_arprot  = r_grant ? S1_AXI_arprot  : S0_AXI_arprot;
    assign g_arvalid = r_grant ? S1_AXI_arvalid : S0_AXI_arvalid;
    assign g_rready  = r_grant ? S1_AXI_rready  : S0_AXI_rready;

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= nxt_state;
            if (r_state == IDLE && (req0 | req1)) begin
                r_grant <= arb_gnt;
                r_err   <= (arb_hi != MMIO_BASE);
            end
            if (r_state != IDLE && nxt_state == IDLE)
                r_last <= r_grant;
        end
    end

    always_comb begin
        nxt_state     = cur_state;
        M_AXI_awaddr  = '0;
        M_AXI_awprot  = '0;
        M_AXI_awvalid = 1'b0;
        M_AXI_wdata   = '0;
        M_AXI_wstrb   = '0;
        M_AXI_wvalid  = 1'b0;
        M_AXI_bready  = 1'b0;
        M_AXI_araddr  = '0;
        M_AXI_arprot  = '0;
        M_AXI_arvalid = 1'b0;
        M_AXI_rready  = 1'b0;
        g_awready     = 1'b0;
        g_wready      = 1'b0;
        g_bvalid      = 1'b0;
        g_bresp       = RESP_OKAY;
        g_arready     = 1'b0;
        g_rvalid      = 1'b0;
        g_rresp       = RESP_OKAY;
        g_rdata       = '0;
        case (cur_state)
            IDLE: begin
                if (req0 | req1)
                    nxt_state = arb_wr ? WR_ADDR : RD_ADDR;
            end
            WR_ADDR: begin
                if (r_err) begin
                    g_awready = 1'b1;
                end else begin
                    M_AXI_awaddr  = g_awaddr;
                    M_AXI_awprot  = g_awprot;
                    M_AXI_awvalid = g_awvalid;
                    g_awready     = M_AXI_awready;
                end
                if (g_awvalid & g_awready) nxt_state = WR_DATA;
            end
            WR_DATA: begin
                if (r_err) begin
                    g_wready = 1'b1;
                end else begin
                    M_AXI_wdata  = g_wdata;
                    M_AXI_wstrb  = g_wstrb;
                    M_AXI_wvalid = g_wvalid;
                    g_wready     = M_AXI_wready;
                end
                if (g_wvalid & g_wready) nxt_state = WR_RESP;
            end
            WR_RESP: begin
                if (r_err) begin
                    g_bvalid = 1'b1;
                    g_bresp  = RESP_DECERR;
                end else begin
                    M_AXI_bready = g_bready;
                    g_bvalid     = M_AXI_bvalid;
                    g_bresp      = M_AXI_bresp;
                end
                if (g_bvalid & g_bready) nxt_state = IDLE;
            end
            RD_ADDR: begin
                if (r_err) begin
                    g_arready = 1'b1;
                end else begin
                    M_AXI_araddr  = g_araddr;
                    M_AXI_arprot  = g_arprot;
                    M_AXI_arvalid = g_arvalid;
                    g_arready     = M_AXI_arready;
                end
                if (g_arvalid & g_arready) nxt_state = RD_RESP;
            end
            RD_RESP: begin
                if (r_err) begin
                    g_rvalid = 1'b1;
                    g_rresp  = RESP_DECERR;
                end else begin
                    M_AXI_rready = g_rready;
                    g_rvalid     = M_AXI_rvalid;
                    g_rresp      = M_AXI_rresp;
                    g_rdata      = M_AXI_rdata;
                end
                if (g_rvalid & g_rready) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Route the granted responses back; the other master sees all zeros.
    assign S0_AXI_awready = g_awready & ~r_grant;
    assign S0_AXI_wready  = g_wready  & ~r_grant;
    assign S0_AXI_bvalid  = g_bvalid  & ~r_grant;
    assign S0_AXI_bresp   = r_grant ? RESP_OKAY : g_bresp;
    assign S0_AXI_arready = g_arready & ~r_grant;
    assign S0_AXI_rvalid  = g_rvalid  & ~r_grant;
    assign S0_AXI_rresp   = r_grant ? RESP_OKAY : g_rresp;
    assign S0_AXI_rdata   = r_grant ? '0 : g_rdata;
    assign S1_AXI_awready = g_awready & r_grant;
    assign S1_AXI_wready  = g_wready  & r_grant;
    assign S1_AXI_bvalid  = g_bvalid  & r_grant;
    assign S1_AXI_bresp   = r_grant ? g_bresp : RESP_OKAY;
    assign S1_AXI_arready = g_arready & r_grant;
    assign S1_AXI_rvalid  = g_rvalid  & r_grant;
    assign S1_AXI_rresp   = r_grant ? g_rresp : RESP_OKAY;
    assign S1_AXI_rdata   = r_grant ? g_rdata : '0;

    assign busy     = (cur_state != IDLE);
    assign grant_id = r_grant & ~arst;

endmodule

// File: tb/tb_axi_mmio_arbiter.sv
// Directed bench for axi_mmio_arbiter: transaction table plus hand-written
// sequences for latency, contention, priority, decode error and reset.
module tb_axi_mmio_arbiter;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic [31:0] s_awaddr [2];
    logic [2:0]  s_awprot [2];
    logic        s_awvalid[2];
    logic        s_awready[2];
    logic [31:0] s_wdata  [2];
    logic [3:0]  s_wstrb  [2];
    logic        s_wvalid [2];
    logic        s_wready [2];
    logic [1:0]  s_bresp  [2];
    logic        s_bvalid [2];
    logic        s_bready [2];
    logic [31:0] s_araddr [2];
    logic [2:0]  s_arprot [2];
    logic        s_arvalid[2];
    logic        s_arready[2];
    logic [31:0] s_rdata  [2];
    logic [1:0]  s_rresp  [2];
    logic        s_rvalid [2];
    logic        s_rready [2];
    logic [31:0] M_awaddr, M_wdata, M_araddr, M_rdata;
    logic [2:0]  M_awprot, M_arprot;
    logic [3:0]  M_wstrb;
    logic [1:0]  M_bresp, M_rresp;
    logic        M_awvalid, M_awready, M_wvalid, M_wready, M_bvalid, M_bready;
    logic        M_arvalid, M_arready, M_rvalid, M_rready;
    logic        busy, grant_id;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    axi_mmio_arbiter #(.MMIO_BASE(16'h4600)) dut (
        .aclk(aclk), .arst(arst),
        .S0_AXI_awaddr(s_awaddr[0]), .S0_AXI_awprot(s_awprot[0]), .S0_AXI_awvalid(s_awvalid[0]),
        .S0_AXI_awready(s_awready[0]), .S0_AXI_wdata(s_wdata[0]), .S0_AXI_wstrb(s_wstrb[0]),
        .S0_AXI_wvalid(s_wvalid[0]), .S0_AXI_wready(s_wready[0]), .S0_AXI_bresp(s_bresp[0]),
        .S0_AXI_bvalid(s_bvalid[0]), .S0_AXI_bready(s_bready[0]), .S0_AXI_araddr(s_araddr[0]),
        .S0_AXI_arprot(s_arprot[0]), .S0_AXI_arvalid(s_arvalid[0]), .S0_AXI_arready(s_arready[0]),
        .S0_AXI_rdata(s_rdata[0]), .S0_AXI_rresp(s_rresp[0]), .S0_AXI_rvalid(s_rvalid[0]),
        .S0_AXI_rready(s_rready[0]),
        .S1_AXI_awaddr(s_awaddr[1]), .S1_AXI_awprot(s_awprot[1]), .S1_AXI_awvalid(s_awvalid[1]),
        .S1_AXI_awready(s_awready[1]), .S1_AXI_wdata(s_wdata[1]), .S1_AXI_wstrb(s_wstrb[1]),
        .S1_AXI_wvalid(s_wvalid[1]), .S1_AXI_wready(s_wready[1]), .S1_AXI_bresp(s_bresp[1]),
        .S1_AXI_bvalid(s_bvalid[1]), .S1_AXI_bready(s_bready[1]), .S1_AXI_araddr(s_araddr[1]),
        .S1_AXI_arprot(s_arprot[1]), .S1_AXI_arvalid(s_arvalid[1]), .S1_AXI_arready(s_arready[1]),
        .S1_AXI_rdata(s_rdata[1]), .S1_AXI_rresp(s_rresp[1]), .S1_AXI_rvalid(s_rvalid[1]),
        .S1_AXI_rready(s_rready[1]),
        .M_AXI_awaddr(M_awaddr), .M_AXI_awprot(M_awprot), .M_AXI_awvalid(M_awvalid),
        .M_AXI_awready(M_awready), .M_AXI_wdata(M_wdata), .M_AXI_wstrb(M_wstrb),
        .M_AXI_wvalid(M_wvalid), .M_AXI_wready(M_wready), .M_AXI_bresp(M_bresp),
        .M_AXI_bvalid(M_bvalid), .M_AXI_bready(M_bready), .M_AXI_araddr(M_araddr),
        .M_AXI_arprot(M_arprot), .M_AXI_arvalid(M_arvalid), .M_AXI_arready(M_arready),
        .M_AXI_rdata(M_rdata), .M_AXI_rresp(M_rresp), .M_AXI_rvalid(M_rvalid),
        .M_AXI_rready(M_rready),
        .busy(busy), .grant_id(grant_id)
    );

    typedef struct {
        logic        m;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] slv_rdata;
        logic [1:0]  slv_resp;
        logic        exp_fwd;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    logic [31:0] comp_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] gnt_q[$];
    logic [31:0] kind_q[$];
    int          rd_left[2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic s_nonzero(input int x);
        return |{s_awready[x], s_wready[x], s_bresp[x], s_bvalid[x], s_arready[x],
                 s_rdata[x], s_rresp[x], s_rvalid[x]};
    endfunction

    function automatic logic all_zero();
        return !(s_nonzero(0) | s_nonzero(1) | busy | grant_id |
                 (|{M_awaddr, M_awprot, M_awvalid, M_wdata, M_wstrb, M_wvalid, M_bready,
                    M_araddr, M_arprot, M_arvalid, M_rready}));
    endfunction

    task automatic clear_inputs();
        for (int x = 0; x < 2; x++) begin
            s_awaddr[x] = '0; s_awprot[x] = '0; s_awvalid[x] = 1'b0;
            s_wdata[x]  = '0; s_wstrb[x]  = '0; s_wvalid[x]  = 1'b0; s_bready[x] = 1'b0;
            s_araddr[x] = '0; s_arprot[x] = '0; s_arvalid[x] = 1'b0; s_rready[x] = 1'b0;
        end
        M_awready = 1'b0; M_wready = 1'b0; M_bresp = '0; M_bvalid = 1'b0;
        M_arready = 1'b0; M_rdata = '0; M_rresp = '0; M_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        arst = 1'b1;
        clear_inputs();
        #1 check("rst_during_zero", all_zero(), 1'b1);
        @(posedge aclk);
        @(posedge aclk);
        #1 arst = 1'b0;
        @(negedge aclk);
        #1 check("rst_after_zero", all_zero(), 1'b1);
    endtask

    // One transaction from an idle arbiter with an always-ready downstream slave.
    task automatic run_txn(input vec_t v, input string nm);
        int          m, o, t_aw, t_w, t_b;
        logic        done, saw_m, other_bad, gnt_bad;
        logic        hs_aw, hs_w, hs_ar, hs_b, hs_r;
        logic [31:0] cap_addr, cap_data, cap_rdata;
        logic [3:0]  cap_strb;
        logic [2:0]  cap_prot;
        logic [1:0]  cap_resp;
        m = int'(v.m); o = 1 - m;
        t_aw = -1; t_w = -1; t_b = -1;
        done = 0; saw_m = 0; other_bad = 0; gnt_bad = 0;
        cap_addr = '0; cap_data = '0; cap_rdata = 32'hFFFF_FFFF; cap_strb = '0; cap_prot = '0;
        cap_resp = 2'bxx;
        @(negedge aclk);
        M_awready = 1; M_wready = 1; M_arready = 1;
        M_bvalid = 1; M_bresp = v.slv_resp;
        M_rvalid = 1; M_rresp = v.slv_resp; M_rdata = v.slv_rdata;
        s_bready[m] = 1; s_rready[m] = 1;
        if (v.wr) begin
            s_awaddr[m] = v.addr; s_awprot[m] = 3'b010; s_awvalid[m] = 1;
            s_wdata[m] = v.data; s_wstrb[m] = 4'b0110; s_wvalid[m] = 1;
        end else begin
            s_araddr[m] = v.addr; s_arprot[m] = 3'b001; s_arvalid[m] = 1;
        end
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) @(negedge aclk);
            #1;
            saw_m     |= M_awvalid | M_wvalid | M_arvalid;
            other_bad |= s_nonzero(o);
            if (busy && grant_id !== v.m) gnt_bad = 1;
            hs_aw = s_awvalid[m] & s_awready[m];
            hs_w  = s_wvalid[m]  & s_wready[m];
            hs_ar = s_arvalid[m] & s_arready[m];
            hs_b  = s_bvalid[m]  & s_bready[m];
            hs_r  = s_rvalid[m]  & s_rready[m];
            if (hs_aw) begin t_aw = c; cap_addr = M_awaddr; cap_prot = M_awprot; end
            if (hs_w)  begin t_w = c; cap_data = M_wdata; cap_strb = M_wstrb; end
            if (hs_ar) begin cap_addr = M_araddr; cap_prot = M_arprot; end
            if (hs_b)  begin t_b = c; cap_resp = s_bresp[m]; end
            if (hs_r)  begin cap_resp = s_rresp[m]; cap_rdata = s_rdata[m]; end
            @(posedge aclk);
            #1;
            if (hs_aw) s_awvalid[m] = 0;
            if (hs_w)  s_wvalid[m]  = 0;
            if (hs_ar) s_arvalid[m] = 0;
            if (hs_b | hs_r) done = 1;
        end
        check({nm, "_done"}, done, 1'b1);
        check({nm, "_mvalid"}, saw_m, v.exp_fwd);
        check({nm, "_resp"}, cap_resp, v.exp_resp);
        check({nm, "_other_zero"}, other_bad, 1'b0);
        check({nm, "_grant"}, gnt_bad, 1'b0);
        if (!v.wr) check({nm, "_rdata"}, cap_rdata, v.exp_rdata);
        if (v.exp_fwd) begin
            check({nm, "_maddr"}, cap_addr, v.addr);
            check({nm, "_mprot"}, cap_prot, v.wr ? 3'b010 : 3'b001);
        end
        if (v.wr) begin
            check({nm, "_order"}, (t_aw >= 0 && t_aw < t_w && t_w < t_b), 1'b1);
            if (v.exp_fwd) begin
                check({nm, "_mwdata"}, cap_data, v.data);
                check({nm, "_mwstrb"}, cap_strb, 4'b0110);
            end
        end
        @(negedge aclk);
        #1 check({nm, "_idle_after"}, busy, 1'b0);
        clear_inputs();
    endtask

    // Free-running masters against an always-ready slave; logs completions in order.
    task automatic run_engine(input string nm);
        logic hs_aw[2], hs_w[2], hs_ar[2], hs_b[2], hs_r[2];
        logic fin;
        comp_q.delete(); wd_q.delete(); gnt_q.delete(); kind_q.delete();
        M_awready = 1; M_wready = 1; M_arready = 1; M_bvalid = 1; M_rvalid = 1;
        M_rdata = 32'h0000_1234;
        fin = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge aclk);
            #1;
            for (int x = 0; x < 2; x++) begin
                hs_aw[x] = s_awvalid[x] & s_awready[x];
                hs_w[x]  = s_wvalid[x]  & s_wready[x];
                hs_ar[x] = s_arvalid[x] & s_arready[x];
                hs_b[x]  = s_bvalid[x]  & s_bready[x];
                hs_r[x]  = s_rvalid[x]  & s_rready[x];
            end
            if (M_wvalid & M_wready) wd_q.push_back(M_wdata);
            if (M_awvalid & M_awready) begin gnt_q.push_back(32'(grant_id)); kind_q.push_back(1); end
            if (M_arvalid & M_arready) begin gnt_q.push_back(32'(grant_id)); kind_q.push_back(0); end
            @(posedge aclk);
            #1;
            for (int x = 0; x < 2; x++) begin
                if (hs_aw[x]) s_awvalid[x] = 0;
                if (hs_w[x])  s_wvalid[x]  = 0;
                if (hs_ar[x]) s_arvalid[x] = 0;
                if (hs_b[x])  comp_q.push_back(32'(2 + x));
                if (hs_r[x]) begin
                    comp_q.push_back(32'(x));
                    if (rd_left[x] > 0) begin rd_left[x]--; s_arvalid[x] = 1; end
                end
            end
            fin = !(s_awvalid[0] | s_awvalid[1] | s_wvalid[0] | s_wvalid[1] |
                    s_arvalid[0] | s_arvalid[1] | busy);
        end
        check({nm, "_finished"}, fin, 1'b1);
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp8[8];
        vecs[0] = '{1'b0, 1'b1, 32'h4600_0010, 32'h0000_00A5, 32'h0,         2'b00, 1'b1, 2'b00, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h4600_0020, 32'h0,         32'h1234_5678, 2'b00, 1'b1, 2'b00, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h1000_0000, 32'h0000_0055, 32'h0,         2'b00, 1'b0, 2'b11, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h4600_0000, 32'h0,         32'h0000_AAAA, 2'b00, 1'b1, 2'b00, 32'h0000_AAAA};
        vecs[4] = '{1'b0, 1'b0, 32'h4601_0000, 32'h0,         32'h7777_7777, 2'b00, 1'b0, 2'b11, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h45FF_FFFC, 32'h0,         32'h7777_7777, 2'b00, 1'b0, 2'b11, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 32'h4600_0008, 32'h00C0_FFEE, 32'h0,         2'b10, 1'b1, 2'b10, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h4600_FFFC, 32'h0,         32'hCAFE_F00D, 2'b01, 1'b1, 2'b01, 32'hCAFE_F00D};
        rd_left[0] = 0; rd_left[1] = 0;
        clear_inputs();

        do_reset();
        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Single S0 read, slave answers three cycles after the AR handshake
        do_reset();
        @(negedge aclk);
        s_araddr[0] = 32'h4600_0104; s_arvalid[0] = 1; s_rready[0] = 1;
        #1 check("rd_arvalid_in_idle", M_arvalid, 1'b0);
        @(negedge aclk);
        #1;
        check("rd_arvalid_next", M_arvalid, 1'b1);
        check("rd_araddr", M_araddr, 32'h4600_0104);
        check("rd_busy", busy, 1'b1);
        M_arready = 1;
        @(posedge aclk);
        #1 s_arvalid[0] = 0; M_arready = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge aclk);
            #1 check("rd_wait_rvalid", s_rvalid[0], 1'b0);
        end
        @(negedge aclk);
        M_rvalid = 1; M_rdata = 32'hDEAD_BEEF; M_rresp = 2'b00;
        #1;
        check("rd_rvalid", s_rvalid[0], 1'b1);
        check("rd_rdata", s_rdata[0], 32'hDEAD_BEEF);
        check("rd_rresp", s_rresp[0], 2'b00);
        check("rd_mrready", M_rready, 1'b1);
        check("rd_s1_zero", s_nonzero(1), 1'b0);
        @(posedge aclk);
        #1 M_rvalid = 0;
        @(negedge aclk);
        #1 check("rd_busy_after", busy, 1'b0);
        clear_inputs();

        // Simultaneous writes from both masters
        do_reset();
        @(negedge aclk);
        s_awaddr[0] = 32'h4600_0000; s_wdata[0] = 32'h11; s_wstrb[0] = 4'hF;
        s_awaddr[1] = 32'h4600_0100; s_wdata[1] = 32'h22; s_wstrb[1] = 4'hF;
        for (int x = 0; x < 2; x++) begin
            s_awvalid[x] = 1; s_wvalid[x] = 1; s_bready[x] = 1; s_rready[x] = 1;
        end
        run_engine("sim_wr");
        check("sim_wr_wd_len", wd_q.size(), 2);
        check("sim_wr_gnt_len", gnt_q.size(), 2);
        if (wd_q.size() == 2 && gnt_q.size() == 2) begin
            check("sim_wr_wd0", wd_q[0], 32'h11);
            check("sim_wr_wd1", wd_q[1], 32'h22);
            check("sim_wr_gnt0", gnt_q[0], 0);
            check("sim_wr_gnt1", gnt_q[1], 1);
        end

        // Sustained read contention: four reads per master
        do_reset();
        @(negedge aclk);
        s_araddr[0] = 32'h4600_0040; s_araddr[1] = 32'h4600_0080;
        for (int x = 0; x < 2; x++) begin
            s_arvalid[x] = 1; s_rready[x] = 1; rd_left[x] = 3;
        end
        run_engine("rr");
        check("rr_len", comp_q.size(), 8);
        if (comp_q.size() == 8) begin
            for (int k = 0; k < 8; k++) exp8[k] = 32'(k % 2);
            for (int k = 0; k < 8; k++) check($sformatf("rr_order%0d", k), comp_q[k], exp8[k]);
        end

        // Write wins over read within one master
        do_reset();
        @(negedge aclk);
        s_awaddr[0] = 32'h4600_0030; s_wdata[0] = 32'h77; s_araddr[0] = 32'h4600_0034;
        s_awvalid[0] = 1; s_wvalid[0] = 1; s_arvalid[0] = 1; s_bready[0] = 1; s_rready[0] = 1;
        run_engine("prio");
        check("prio_len", comp_q.size(), 2);
        check("prio_kind_len", kind_q.size(), 2);
        if (comp_q.size() == 2 && kind_q.size() == 2) begin
            check("prio_first_write", comp_q[0], 2);
            check("prio_then_read", comp_q[1], 0);
            check("prio_first_maw", kind_q[0], 1);
        end

        // Reset while waiting in WR_RESP
        do_reset();
        @(negedge aclk);
        M_awready = 1; M_wready = 1;
        s_awaddr[0] = 32'h4600_0050; s_wdata[0] = 32'h99; s_awvalid[0] = 1; s_wvalid[0] = 1;
        s_bready[0] = 1;
        @(posedge aclk);
        @(posedge aclk);
        #1 s_awvalid[0] = 0;
        @(posedge aclk);
        #1 s_wvalid[0] = 0;
        @(negedge aclk);
        #1;
        check("rstmid_busy", busy, 1'b1);
        check("rstmid_mbready", M_bready, 1'b1);
        arst = 1;
        #1 check("rstmid_during_zero", all_zero(), 1'b1);
        @(posedge aclk);
        #1 arst = 0;
        clear_inputs();
        @(negedge aclk);
        #1 check("rstmid_after_zero", all_zero(), 1'b1);
        run_txn('{1'b1, 1'b0, 32'h4600_0200, 32'h0, 32'h0BAD_F00D, 2'b00, 1'b1, 2'b00, 32'h0BAD_F00D},
                "rstmid_s1_read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
